// File: rtl/mem_copy_initiator.sv
// Request-side engine for a synchronous RAM: copies LEN words from SRC to DST,
// or fills LEN words at DST with a constant, one RAM request per cycle.
module mem_copy_initiator #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              read_rq,
    output logic              write_rq,
    output logic [ADDR_W-1:0] rw_address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        NEXT,
        RD,
        WR,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   fill_q, fill_d;

    logic                busy_d, done_d, read_rq_d, write_rq_d;
    logic [ADDR_W-1:0]   rw_address_d;
    logic [DATA_W-1:0]   write_data_d;

    // State, command and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            src_ptr_q  <= '0;
            dst_ptr_q  <= '0;
            rem_q      <= '0;
            fill_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            read_rq    <= 1'b0;
            write_rq   <= 1'b0;
            rw_address <= '0;
            write_data <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            src_ptr_q  <= src_ptr_d;
            dst_ptr_q  <= dst_ptr_d;
            rem_q      <= rem_d;
            fill_q     <= fill_d;
            busy       <= busy_d;
            done       <= done_d;
            read_rq    <= read_rq_d;
            write_rq   <= write_rq_d;
            rw_address <= rw_address_d;
            write_data <= write_data_d;
        end
    end

    // Next state; outputs are derived from the state being entered so they
    // line up with it once registered. WR skips NEXT to keep requests back to back.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        rem_d        = rem_q;
        fill_d       = fill_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        read_rq_d    = 1'b0;
        write_rq_d   = 1'b0;
        rw_address_d = '0;
        write_data_d = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = NEXT;
                    mode_d    = mode;
                    src_ptr_d = src_addr;
                    dst_ptr_d = dst_addr;
                    rem_d     = length;
                    fill_d    = fill_data;
                end
            end
            NEXT, WR: begin
                if (rem_q == LEN_W'(0)) begin
                    state_d = DONE;
                end else begin
                    state_d = mode_q ? WR : RD;
                end
            end
            RD:      state_d = WR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == NEXT) || (state_d == RD) || (state_d == WR);
        done_d = (state_d == DONE);

        if (state_d == RD) begin
            read_rq_d    = 1'b1;
            rw_address_d = src_ptr_q;
            src_ptr_d    = src_ptr_q + ADDR_W'(1);
        end

        // The write_data register doubles as the read-data hold register.
        if (state_d == WR) begin
            write_rq_d   = 1'b1;
            rw_address_d = dst_ptr_q;
            write_data_d = mode_q ? fill_q : read_data;
            dst_ptr_d    = dst_ptr_q + ADDR_W'(1);
            rem_d        = rem_q - LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Directed bench for mem_copy_initiator with a behavioural 64x16 RAM and request log.
module tb_mem_copy_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [5:0]  src_addr;
    logic [5:0]  dst_addr;
    logic [6:0]  length;
    logic [15:0] fill_data;
    logic        busy;
    logic        done;
    logic        read_rq;
    logic        write_rq;
    logic [5:0]  rw_address;
    logic [15:0] write_data;
    logic [15:0] read_data;

    logic [15:0] mem [64];
    logic        tb_we;
    logic [5:0]  tb_addr;
    logic [15:0] tb_data;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int req_log [$];
    int req_cyc [$];

    mem_copy_initiator #(.ADDR_W(6), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .fill_data  (fill_data),
        .busy       (busy),
        .done       (done),
        .read_rq    (read_rq),
        .write_rq   (write_rq),
        .rw_address (rw_address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: combinational read, write at the clock edge
    assign read_data = read_rq ? mem[rw_address] : 16'h0;
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (write_rq) mem[rw_address] <= write_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Request log: reads as address, writes as 1000+address
    always @(negedge clk) begin
        if (read_rq || write_rq) begin
            check("rw_exclusive", 32'(read_rq & write_rq), 32'd0);
            req_log.push_back(write_rq ? 1000 + int'(rw_address) : int'(rw_address));
            req_cyc.push_back(cyc);
        end
    end

    task automatic poke(input int a, input logic [15:0] d);
        @(negedge clk);
        tb_addr = 6'(a);
        tb_data = d;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    task automatic start_cmd(input logic m, input int s, input int d, input int l,
                             input logic [15:0] f, output int t0);
        @(negedge clk);
        mode      = m;
        src_addr  = 6'(s);
        dst_addr  = 6'(d);
        length    = 7'(l);
        fill_data = f;
        start     = 1'b1;
        t0        = cyc;
        req_log.delete();
        req_cyc.delete();
    endtask

    // Waits for done (bounded); optionally pulses a conflicting start at iteration poke_at
    task automatic wait_done(input int t0, input int poke_at, output int lat);
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 0) begin
                check("busy_after_start", 32'(busy), 32'd1);
                src_addr  = 6'd33;
                dst_addr  = 6'd44;
                length    = 7'd9;
                fill_data = 16'hFFFF;
            end
            if (i == poke_at) begin
                mode      = 1'b1;
                dst_addr  = 6'd40;
                length    = 7'd5;
                fill_data = 16'hDEAD;
                start     = 1'b1;
            end
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    int t0, lat, bad;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        length = '0; fill_data = '0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd", 32'(read_rq), 32'd0);
        check("rst_wr", 32'(write_rq), 32'd0);
        check("rst_addr", 32'(rw_address), 32'd0);
        check("rst_wdata", 32'(write_data), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) poke(i, 16'(16'h1000 + i));
        for (int i = 0; i < 4; i++) poke(10 + i, 16'(i + 1));

        // Fill 3 words at 4
        start_cmd(1'b1, 0, 4, 3, 16'hBEEF, t0);
        wait_done(t0, -1, lat);
        check("fill_lat", 32'(lat), 32'd5);
        check("fill_nreq", 32'(req_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) check("fill_seq", 32'(req_log[i]), 32'(1004 + i));
        check("fill_consecutive", 32'(req_cyc[2] - req_cyc[0]), 32'd2);
        check("fill_m4", 32'(mem[4]), 32'hBEEF);
        check("fill_m6", 32'(mem[6]), 32'hBEEF);
        check("fill_m3", 32'(mem[3]), 32'h1003);
        check("fill_m7", 32'(mem[7]), 32'h1007);

        // Copy 10..13 -> 20..23
        start_cmd(1'b0, 10, 20, 4, 16'h0, t0);
        wait_done(t0, -1, lat);
        check("copy_lat", 32'(lat), 32'd10);
        check("copy_nreq", 32'(req_log.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check("copy_rd_seq", 32'(req_log[2*i]), 32'(10 + i));
            check("copy_wr_seq", 32'(req_log[2*i+1]), 32'(1020 + i));
            check("copy_data", 32'(mem[20 + i]), 32'(i + 1));
        end
        check("copy_span", 32'(req_cyc[7] - req_cyc[0]), 32'd7);

        // Wrapping copy 62,63,0,1 -> 0..3 propagates already-written words
        start_cmd(1'b0, 62, 0, 4, 16'h0, t0);
        wait_done(t0, -1, lat);
        check("wrap_lat", 32'(lat), 32'd10);
        check("wrap_r0", 32'(req_log[0]), 32'd62);
        check("wrap_r1", 32'(req_log[2]), 32'd63);
        check("wrap_r2", 32'(req_log[4]), 32'd0);
        check("wrap_r3", 32'(req_log[6]), 32'd1);
        check("wrap_w3", 32'(req_log[7]), 32'd1003);
        check("wrap_m0", 32'(mem[0]), 32'h103E);
        check("wrap_m1", 32'(mem[1]), 32'h103F);
        check("wrap_m2", 32'(mem[2]), 32'h103E);
        check("wrap_m3", 32'(mem[3]), 32'h103F);

        // Zero length
        start_cmd(1'b1, 0, 9, 0, 16'h1234, t0);
        wait_done(t0, -1, lat);
        check("len0_lat", 32'(lat), 32'd2);
        check("len0_nreq", 32'(req_log.size()), 32'd0);

        // Full-memory fill from 17
        start_cmd(1'b1, 0, 17, 64, 16'h5A5A, t0);
        wait_done(t0, -1, lat);
        check("full_lat", 32'(lat), 32'd66);
        check("full_nreq", 32'(req_log.size()), 32'd64);
        check("full_first", 32'(req_log[0]), 32'd1017);
        check("full_wrap_hi", 32'(req_log[46]), 32'd1063);
        check("full_wrap_lo", 32'(req_log[47]), 32'd1000);
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 16'h5A5A) bad++;
        check("full_contents", 32'(bad), 32'd0);

        // Start while busy is ignored
        poke(0, 16'h0011); poke(1, 16'h0022); poke(2, 16'h0033); poke(3, 16'h0044);
        start_cmd(1'b0, 0, 8, 4, 16'h0, t0);
        wait_done(t0, 3, lat);
        check("busy_start_lat", 32'(lat), 32'd10);
        check("busy_start_nreq", 32'(req_log.size()), 32'd8);
        check("busy_start_m8", 32'(mem[8]), 32'h0011);
        check("busy_start_m11", 32'(mem[11]), 32'h0044);
        check("busy_start_m40", 32'(mem[40]), 32'h5A5A);

        // Reset on the third request cycle of a copy
        start_cmd(1'b0, 0, 50, 4, 16'h0, t0);
        repeat (4) @(negedge clk);
        start = 1'b0;
        check("pre_rst_rd", 32'(read_rq), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_rd", 32'(read_rq), 32'd0);
        check("mid_rst_wr", 32'(write_rq), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);
        check("partial_m50", 32'(mem[50]), 32'h0011);
        check("partial_m51", 32'(mem[51]), 32'h5A5A);

        start_cmd(1'b1, 0, 60, 2, 16'h7777, t0);
        wait_done(t0, -1, lat);
        check("after_rst_lat", 32'(lat), 32'd4);
        check("after_rst_m60", 32'(mem[60]), 32'h7777);
        check("after_rst_m61", 32'(mem[61]), 32'h7777);
        check("after_rst_m62", 32'(mem[62]), 32'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
